// File: rtl/mipu_clk_pkg.sv
// Shared clocking definitions for blocks on B_CLK that track the divided CPU clock:
// bridge FSM states, default divider width and the derived phase constants.
package mipu_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } bridge_state_t;

  localparam int DIV_LOG2_DEF = 3;

  function automatic int half_ph(input int div_log2);
    return 2 ** (div_log2 - 1);
  endfunction

  // Longest memory latency that still registers the result one cycle before the CPU edge
  function automatic int max_mem_lat(input int div_log2);
    return (2 ** div_log2) - 4;
  endfunction

  localparam int HALF_PH     = half_ph(DIV_LOG2_DEF);
  localparam int CAPTURE_PH  = HALF_PH + 1;
  localparam int CPU_EDGE_PH = HALF_PH - 1;

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// CPU request / memory access bundle for cpu_mem_bridge.
// The slave modport is the bridge's view; master is the CPU-plus-memory side.
interface cpu_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_late;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata, err_late
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata, err_late
  );
endinterface

// File: rtl/clk_phase_cnt.sv
// Free-running phase counter, bit-identical to the CPU clock divider counter,
// so B_CLK-domain logic knows where each CPU edge falls.
module clk_phase_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             B_CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] ph
);

  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) ph <= '0;
    else     ph <= ph + 1'b1;
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Carries CPU-clock memory accesses into the B_CLK memory domain, finishing before the next CPU edge.
// Optional deadline-miss flag built when CPU_MEM_BRIDGE_CHK_EN is defined.
module cpu_mem_bridge
  import mipu_clk_pkg::*;
#(
  parameter int DIV_LOG2 = DIV_LOG2_DEF,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2
) (
  input logic             B_CLK,
  input logic             RST,
  cpu_mem_bridge_if.slave bus
);

  localparam int HALF = half_ph(DIV_LOG2);
  localparam logic [DIV_LOG2-1:0] CAP_PH = DIV_LOG2'(HALF + 1);
  localparam logic [DIV_LOG2-1:0] LAT_M1 = DIV_LOG2'(MEM_LAT - 1);

  logic [DIV_LOG2-1:0] ph;
  logic [DIV_LOG2-1:0] wait_cnt;
  bridge_state_t       state;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                cpu_ready_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                err_late_q;

  clk_phase_cnt #(.WIDTH(DIV_LOG2)) u_phase (
    .B_CLK (B_CLK),
    .RST   (RST),
    .ph    (ph)
  );

  // The capture edge overrides whatever the FSM is doing; mem_we_q doubles as the latched direction
  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (ph == CAP_PH) begin
      cpu_ready_q <= 1'b0;
      mem_en_q    <= bus.cpu_req;
      mem_we_q    <= bus.cpu_req & bus.cpu_we;
      if (bus.cpu_req) begin
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
        state       <= ISSUE;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            cpu_ready_q <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= LAT_M1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            cpu_rdata_q <= bus.mem_rdata;
            cpu_ready_q <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_MEM_BRIDGE_CHK_EN
  localparam logic [DIV_LOG2-1:0] EDGE_PH = DIV_LOG2'(HALF - 1);

  // Still busy when the CPU samples means the result cannot be valid in time
  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) begin
      err_late_q <= 1'b0;
    end else if ((ph == EDGE_PH) && ((state == ISSUE) || (state == WAIT))) begin
      err_late_q <= 1'b1;
    end
  end
`else
  assign err_late_q = 1'b0;
`endif

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err_late  = err_late_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed table, reset corner cases, random periods
// against a per-CPU-period reference model, and a deadline-miss instance with MEM_LAT=5.
module tb_cpu_mem_bridge;
  import mipu_clk_pkg::*;

  localparam int PER     = 2 ** DIV_LOG2_DEF;
  localparam int MEM_LAT = 2;
`ifdef CPU_MEM_BRIDGE_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  logic B_CLK = 1'b0;
  logic RST   = 1'b1;
  int   tb_ph;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem_store [256];
  logic [31:0] ref_mem   [256];
  logic [31:0] pipe1, pipe2;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic        prev_req;
  vec_t        tbl [8];

  cpu_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  cpu_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_l ();

  cpu_mem_bridge #(.DIV_LOG2(DIV_LOG2_DEF), .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .B_CLK (B_CLK),
    .RST   (RST),
    .bus   (bus.slave)
  );

  cpu_mem_bridge #(.DIV_LOG2(DIV_LOG2_DEF), .ADDR_W(32), .DATA_W(32), .MEM_LAT(5)) dut_late (
    .B_CLK (B_CLK),
    .RST   (RST),
    .bus   (bus_l.slave)
  );

  always #5 B_CLK = ~B_CLK;

  always @(posedge B_CLK or posedge RST) begin
    if (RST) tb_ph <= 0;
    else     tb_ph <= (tb_ph + 1) % PER;
  end

  // Memory with a two-cycle read pipeline
  always @(posedge B_CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_store[bus.mem_addr[9:2]] <= bus.mem_wdata;
      pipe1 <= mem_store[bus.mem_addr[9:2]];
    end
    pipe2 <= pipe1;
  end
  assign bus.mem_rdata   = pipe2;
  assign bus_l.mem_rdata = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic toPh4();
    int guard = 0;
    while (tb_ph != 4 && guard < 2 * PER) begin
      @(negedge B_CLK);
      guard++;
    end
    checkOutput("align_ph4", 32'(tb_ph), 32'd4);
  endtask

  // One CPU period starting at the PH=4 sample; s counts samples after the capture edge
  task automatic applyStimulus(input vec_t v);
    int          lat;
    logic [31:0] new_rd, rd;
    logic        exp_ready;
    logic        exp_en;
    bus.cpu_req   = v.req;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    lat    = v.we ? 2 : MEM_LAT + 2;
    new_rd = (v.req && !v.we) ? ref_mem[v.addr[9:2]] : exp_rdata;
    for (int s = 0; s < PER; s++) begin
      @(negedge B_CLK);
      exp_ready = (s == 0) ? prev_req : (v.req && s >= lat);
      exp_en    = v.req && (s == 1);
      if (s == 1 && v.req) begin
        exp_addr  = v.addr;
        exp_wdata = v.wdata;
      end
      rd = (v.req && !v.we && s >= lat) ? new_rd : exp_rdata;
      checkOutput("phase",     32'(dut.ph), 32'((CAPTURE_PH + s) % PER));
      checkOutput("cpu_ready", 32'(bus.cpu_ready), 32'(exp_ready));
      checkOutput("mem_en",    32'(bus.mem_en), 32'(exp_en));
      checkOutput("mem_we",    32'(bus.mem_we), 32'(exp_en && v.we));
      checkOutput("mem_addr",  bus.mem_addr, exp_addr);
      checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
      checkOutput("cpu_rdata", bus.cpu_rdata, rd);
      checkOutput("err_late",  32'(bus.err_late), 32'd0);
    end
    exp_rdata = new_rd;
    prev_req  = v.req;
    if (v.req && v.we) ref_mem[v.addr[9:2]] = v.wdata;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      mem_store[i] = 32'hA500_0000 | 32'(i << 2);
      ref_mem[i]   = 32'hA500_0000 | 32'(i << 2);
    end
    mem_store[16] = 32'hDEAD_BEEF;
    ref_mem[16]   = 32'hDEAD_BEEF;
    pipe1 = '0; pipe2 = '0;
    exp_rdata = '0; exp_addr = '0; exp_wdata = '0; prev_req = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 32'hA500_0010};
    tbl[4] = '{1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b1, 32'hA500_0010};
    tbl[5] = '{1'b1, 1'b0, 32'h18, 32'h0,         1'b1, 32'hA500_0018};
    tbl[6] = '{1'b1, 1'b0, 32'h14, 32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[7] = '{1'b1, 1'b0, 32'h80, 32'h0,         1'b1, 32'h1234_5678};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus_l.cpu_req = 0; bus_l.cpu_we = 0; bus_l.cpu_addr = '0; bus_l.cpu_wdata = '0;

    // Reset and idle run
    repeat (3) @(posedge B_CLK);
    @(negedge B_CLK);
    RST = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge B_CLK);
      checkOutput("idle_phase", 32'(dut.ph), 32'(c % PER));
      checkOutput("idle_ready", 32'(bus.cpu_ready), 32'd0);
      checkOutput("idle_en",    32'(bus.mem_en), 32'd0);
      checkOutput("idle_we",    32'(bus.mem_we), 32'd0);
      checkOutput("idle_rdata", bus.cpu_rdata, 32'd0);
      checkOutput("idle_addr",  bus.mem_addr, 32'd0);
      checkOutput("idle_wdata", bus.mem_wdata, 32'd0);
      checkOutput("idle_err",   32'(bus.err_late), 32'd0);
      checkOutput("late_err0",  32'(bus_l.err_late), 32'd0);
    end

    // Directed table, including back-to-back accesses
    toPh4();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkOutput("tbl_ready", 32'(bus.cpu_ready), 32'(tbl[i].exp_ready));
      checkOutput("tbl_rdata", bus.cpu_rdata, tbl[i].exp_rdata);
    end

    // Reset in the middle of a read (state WAIT during PH=7)
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40; bus.cpu_wdata = '0;
    repeat (3) @(negedge B_CLK);
    checkOutput("mid_ph7", 32'(tb_ph), 32'd7);
    RST = 1'b1;
    #1;
    checkOutput("mid_en",    32'(bus.mem_en), 32'd0);
    checkOutput("mid_ready", 32'(bus.cpu_ready), 32'd0);
    checkOutput("mid_rdata", bus.cpu_rdata, 32'd0);
    checkOutput("mid_addr",  bus.mem_addr, 32'd0);
    repeat (2) @(negedge B_CLK);
    RST = 1'b0;
    bus.cpu_addr = 32'h44;
    for (int c = 1; c <= PER; c++) begin
      @(negedge B_CLK);
      checkOutput("post_phase", 32'(dut.ph), 32'(c % PER));
      checkOutput("post_en",    32'(bus.mem_en), 32'(c == 6));
    end
    checkOutput("post_addr", bus.mem_addr, 32'h44);
    prev_req  = 1'b1;
    exp_rdata = ref_mem[17];
    exp_addr  = 32'h44;
    exp_wdata = 32'h0;
    toPh4();

    // Random periods against the model
    for (int i = 0; i < 40; i++) begin
      v.req       = ($urandom_range(0, 3) != 0);
      v.we        = 1'($urandom_range(0, 1));
      v.addr      = 32'($urandom_range(0, 255)) << 2;
      v.wdata     = $urandom;
      v.exp_ready = v.req;
      v.exp_rdata = '0;
      applyStimulus(v);
    end

    // Deadline miss with MEM_LAT=5
    bus.cpu_req = 0;
    bus_l.cpu_req = 1; bus_l.cpu_we = 0; bus_l.cpu_addr = 32'h8;
    for (int s = 0; s < PER; s++) begin
      @(negedge B_CLK);
      if (tb_ph == CPU_EDGE_PH)     checkOutput("late_before_edge", 32'(bus_l.err_late), 32'd0);
      if (tb_ph == CPU_EDGE_PH + 1) checkOutput("late_after_edge",  32'(bus_l.err_late), 32'(CHK));
    end
    bus_l.cpu_req = 0;
    repeat (16) @(negedge B_CLK);
    checkOutput("late_sticky", 32'(bus_l.err_late), 32'(CHK));
    checkOutput("main_no_err", 32'(bus.err_late), 32'd0);
    RST = 1'b1;
    #1;
    checkOutput("late_reset", 32'(bus_l.err_late), 32'd0);
    @(negedge B_CLK);
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Synchronous bridge that carries CPU-side memory accesses into the base-clock memory domain and returns results before the next CPU clock edge. The CPU issues requests on the divided CPU clock (B_CLK / 2^DIV_LOG2, rising when the divider MSB rises). The memory and this block run on B_CLK. The block keeps an internal phase counter that is bit-identical to the clock divider's counter, so it knows where every CPU edge falls without sampling the divided clock.

## Interface
- DIV_LOG2, 3: CPU period = 2^DIV_LOG2 B_CLK cycles; legal range ≥ 3.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 2: memory read latency in B_CLK cycles; legal range 1 … 2^DIV_LOG2 − 4.

Ports:
- B_CLK in 1: base clock, the same clock that drives the divider and memory.
- RST in 1: reset, asynchronous, active-high, the same net as the divider reset.
- cpu_req in 1: access request, held stable for a full CPU period.
- cpu_we in 1: 1 = write, 0 = read.
- cpu_addr in ADDR_W: access address.
- cpu_wdata in DATA_W: write data.
- cpu_rdata out DATA_W: read result, registered.
- cpu_ready out 1: access complete; valid for the CPU edge.
- mem_en out 1: one-cycle memory strobe.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data.
- err_late out 1: sticky deadline-miss flag.

## Operation
- **Phase counter PH.**
  - DIV_LOG2 bits, reset 0, increments every B_CLK edge and wraps.
  - Let H = 2^(DIV_LOG2−1). "Ek" denotes the B_CLK edge where PH goes from k to k+1.
  - The CPU clock rises at E(H−1).
- **FSM states.** IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **Capture at E(H+1).** At this edge, in any state:
  - If cpu_req=1: latch cpu_we, cpu_addr and cpu_wdata; clear cpu_ready; go to ISSUE.
  - If cpu_req=0: clear cpu_ready; go to IDLE; cpu_rdata holds its value.
- **ISSUE (one cycle).**
  - mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - A write goes to DONE next.
  - A read loads the wait counter with MEM_LAT−1 and goes to WAIT.
- **WAIT.**
  - The counter decrements each cycle.
  - On the edge that ends the cycle where the count is 0, mem_rdata is registered into cpu_rdata and the FSM goes to DONE.
- **DONE.** cpu_ready=1, held until the next capture edge.
- **Outside ISSUE.** mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- **Deadline check.** If the FSM is in ISSUE or WAIT at edge E(H−1), err_late is set and stays set until RST. The FSM continues unaffected.
- **Async reset.** RST at any time, including mid-access, immediately forces PH=0 and state IDLE, and drives every output to 0. The in-flight access is abandoned and no memory strobe is produced.

## Timing
- **Reset values.** cpu_rdata=0, cpu_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, err_late=0.
- **Defaults** (DIV_LOG2=3, MEM_LAT=2):
  - capture at E5;
  - mem_en high during PH=6;
  - a write's cpu_ready rises after E6;
  - a read's mem_rdata is sampled at E0, with cpu_rdata and cpu_ready valid from PH=1;
  - the CPU samples at E3.
- **Read latency.** Capture to cpu_ready is MEM_LAT+2 B_CLK cycles.
- **Write latency.** Capture to cpu_ready is 2 B_CLK cycles.
- **Margin.** At the legal maximum MEM_LAT, the result registers at E(H−2), leaving one full B_CLK cycle of setup before the CPU edge.
- **Back-to-back requests.** One access per CPU period. A new capture in DONE drops cpu_ready on that same edge.

## Configuration
- **Macro:** CPU_MEM_BRIDGE_CHK_EN.
- **Defined:** the deadline check is built and err_late behaves as specified.
- **Undefined:** the check logic is omitted and err_late is tied to 0. The port remains present.

## Structure
- **Shared package `mipu_clk_pkg`:**
  - the FSM state enum (IDLE/ISSUE/WAIT/DONE);
  - default DIV_LOG2;
  - the derived constants HALF_PH, CAPTURE_PH = HALF_PH+1 and CPU_EDGE_PH = HALF_PH−1;
  - a function returning the maximum legal MEM_LAT.
- **Sub-module `clk_phase_cnt`:** the PH counter, instanced once. It is also reusable by any other B_CLK-domain block that needs CPU-edge alignment.

## Test plan
All scenarios use the defaults unless stated.

1. **Reset.** Assert RST for 3 cycles, release, run 16 cycles with cpu_req=0 → every output is 0, mem_en never pulses, and PH matches the divider counter each cycle.
2. **Read.** cpu_req=1, we=0, addr=0x40 at E5; the memory model returns 0xDEADBEEF with 2-cycle latency → exactly one mem_en pulse at PH=6 with mem_addr=0x40; cpu_rdata=0xDEADBEEF and cpu_ready=1 from PH=1 through E5.
3. **Write.** we=1, addr=0x80, wdata=0x12345678 → mem_en=1 and mem_we=1 at PH=6 with matching address and data; cpu_ready=1 after E6; cpu_rdata unchanged.
4. **Back-to-back.** Read 0x10, then write 0x14, then read 0x18 on consecutive CPU periods → three mem_en pulses, 8 cycles apart; cpu_ready drops at each E5; err_late stays 0.
5. **Reset mid-access.** RST asserted during WAIT → mem_en=0, cpu_ready=0 and cpu_rdata=0 immediately; after release, the next capture occurs at E5 of the fresh PH sequence.
6. **Deadline miss.** With CPU_MEM_BRIDGE_CHK_EN defined and MEM_LAT forced to 5 (illegal) → err_late=1 at E3 and sticky until RST. With the macro undefined → err_late=0 throughout.
